uart_cal_ctrl: RTL and testbench
================================

Name: uart_cal_ctrl

Overview:
- Command sequencer between the UART byte interface (rx byte stream in, tx byte stream out) and a small 8-bit calculator datapath inside this block.
- Collects a 4-byte command frame from the receiver, executes one arithmetic/logic operation and returns a 3-byte response frame through the transmitter using a valid/ready handshake.
- Sits at the top of the calculator design, directly between the rx and tx byte ports of the UART.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1000000, max clk cycles allowed between consecutive bytes within a frame.
- ERR_CNT_W, 8, width of the error counters.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  1-cycle strobe, rx_data valid
- tx_data  output  8  byte to transmit
- tx_valid  output  1  1-cycle strobe, tx_data valid
- tx_ready  input  1  transmitter idle and able to accept a byte
- busy  output  1  high in any state other than IDLE
- frame_err_cnt  output  ERR_CNT_W  count of timeouts, saturating
- overrun_cnt  output  ERR_CNT_W  count of rx bytes dropped while responding, saturating

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All of the following go to 0: tx_data, tx_valid, busy, frame_err_cnt, overrun_cnt, operand/opcode registers, timeout counter. State goes to IDLE.
- Reset asserted mid-frame or mid-response aborts immediately. No further tx_valid until a new frame is received.
- Frame format: SYNC, OPCODE, A, B.
- Response format: STATUS, RES_HI, RES_LO.
- FSM states and transitions:
  - IDLE: on rx_valid with rx_data==SYNC_BYTE, go to GET_OP. Any other byte is silently ignored.
  - GET_OP: on rx_valid, latch opcode, go to GET_A.
  - GET_A: on rx_valid, latch A, go to GET_B.
  - GET_B: on rx_valid, latch B, go to EXEC.
  - EXEC: one cycle. Registers the 16-bit result and 8-bit status, then goes to SEND_ST.
  - SEND_ST, SEND_HI, SEND_LO: each waits for tx_ready==1 and no gap pending, drives tx_data, pulses tx_valid for exactly 1 cycle, then advances. SEND_LO returns to IDLE after its pulse.
- Tx gap rule: after each tx_valid pulse, tx_ready is ignored for the following cycle, because the transmitter drops ready one cycle late. Minimum spacing between pulses is therefore 2 cycles. tx_data holds its value until the next pulse.
- Latency: tx_valid for STATUS occurs no earlier than 2 cycles after the rx_valid carrying B (EXEC cycle plus registered output), given tx_ready=1.
- Timeout:
  - In GET_OP, GET_A and GET_B the counter increments each cycle and clears on rx_valid.
  - When it reaches TIMEOUT_CYC-1 without a byte, return to IDLE and increment frame_err_cnt.
  - A byte arriving on the timeout cycle takes priority: it is accepted and no error is counted.
- Overrun: an rx_valid during EXEC or any SEND state drops the byte and increments overrun_cnt. State is unaffected.
- Counters saturate at all-ones. No wrap-around.
- Opcodes (A and B zero-extended to 16 bits):
  - 0x00 ADD = A+B (max 0x01FE)
  - 0x01 SUB = A-B mod 2^16 (e.g. 1-2 = 0xFFFF)
  - 0x02 MUL = A*B (max 0xFE01)
  - 0x03 AND, 0x04 OR, 0x05 XOR, each computed on 8 bits with RES_HI=0
  - Status is 0x00 for a valid opcode.
  - Any other opcode: status 0xE1, result 0x0000. The response is still sent.
- Mid-frame SYNC bytes are treated as data (no resynchronisation).
- busy is registered and is high exactly when state != IDLE.

Decomposition:
- Shared package uart_cal_pkg:
  - state enum
  - opcode constants OP_ADD through OP_XOR
  - status constants ST_OK=8'h00, ST_BAD_OP=8'hE1
- One natural sub-module, cal_alu: combinational; opcode, a, b in; result[15:0], bad_op out. The FSM registers its outputs in EXEC.

Test Plan:
- Send A5 00 12 34 with tx_ready held 1 -> tx bytes 00, 00, 46. tx_valid pulses are at least 2 cycles apart. busy falls after the final pulse.
- Send A5 02 FF FF, then A5 01 01 02 -> responses 00 FE 01, then 00 FF FF.
- Send A5 07 01 01 -> response E1 00 00. Send 11 22 A5 05 F0 3C -> leading 11 and 22 ignored, response 00 00 CC.
- Send A5 00, then idle TIMEOUT_CYC cycles -> no tx_valid, frame_err_cnt=1, busy=0. Next, a byte delivered exactly on the timeout cycle is accepted and frame_err_cnt stays at 1.
- Hold tx_ready=0 for 50 cycles after the frame, inject 2 rx bytes during that window -> no tx_valid while ready is low, overrun_cnt=2, response intact once ready returns.
- Assert rst during SEND_HI -> tx_valid=0, busy=0 and all counters 0 within the same cycle. A subsequent clean frame gives a correct response.

Source files
------------

// File: rtl/uart_cal_pkg.sv
// rtl/uart_cal_pkg.sv - shared types and constants for the UART calculator controller
//
// Purpose: FSM state encoding, calculator opcodes and response status codes
//          shared by uart_cal_ctrl and cal_alu.
package uart_cal_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_OP  = 3'd1,
    S_GET_A   = 3'd2,
    S_GET_B   = 3'd3,
    S_EXEC    = 3'd4,
    S_SEND_ST = 3'd5,
    S_SEND_HI = 3'd6,
    S_SEND_LO = 3'd7
  } state_t;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_XOR = 8'h05;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BAD_OP = 8'hE1;

endpackage

// File: rtl/cal_alu.sv
// rtl/cal_alu.sv - combinational 8-bit calculator datapath
//
// Purpose: computes one 16-bit result from an opcode and two 8-bit operands.
// Ports:
//   opcode  in  8   operation select
//   a, b    in  8   operands (zero-extended to 16 bits)
//   result  out 16  operation result, 0 for an unknown opcode
//   bad_op  out 1   opcode is not a defined operation
module cal_alu
  import uart_cal_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result,
  output logic        bad_op
);

  logic [15:0] w_a16;
  logic [15:0] w_b16;

  assign w_a16 = {8'h00, a};
  assign w_b16 = {8'h00, b};

  always_comb begin
    result = 16'h0000;
    bad_op = 1'b0;
    case (opcode)
      OP_ADD:  result = w_a16 + w_b16;
      OP_SUB:  result = w_a16 - w_b16;
      OP_MUL:  result = w_a16 * w_b16;
      OP_AND:  result = {8'h00, a & b};
      OP_OR:   result = {8'h00, a | b};
      OP_XOR:  result = {8'h00, a ^ b};
      default: bad_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_cal_ctrl.sv
// rtl/uart_cal_ctrl.sv - command sequencer between UART rx/tx bytes and the calculator
//
// Purpose: collects SYNC,OPCODE,A,B from the receiver, executes one operation and
//          returns STATUS,RES_HI,RES_LO through the transmitter.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   rx_data/valid   received byte and its 1-cycle strobe
//   tx_data/valid   byte to transmit and its 1-cycle strobe
//   tx_ready        transmitter can accept a byte
//   busy            state is not IDLE
//   frame_err_cnt   saturating count of inter-byte timeouts
//   overrun_cnt     saturating count of rx bytes dropped while responding
module uart_cal_ctrl
  import uart_cal_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] frame_err_cnt,
  output logic [ERR_CNT_W-1:0] overrun_cnt
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t               r_state;
  logic [7:0]           r_opcode;
  logic [7:0]           r_a;
  logic [7:0]           r_b;
  logic [15:0]          r_result;
  logic [7:0]           r_status;
  logic [TO_W-1:0]      r_to_cnt;
  logic [ERR_CNT_W-1:0] r_frame_err;
  logic [ERR_CNT_W-1:0] r_overrun;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_busy;

  state_t      w_next_state;
  logic        w_timeout;
  logic        w_in_frame;
  logic        w_in_resp;
  logic        w_is_send;
  logic        w_send_go;
  logic [7:0]  w_send_byte;
  logic [15:0] w_alu_result;
  logic        w_alu_bad_op;

  cal_alu u_alu (
    .opcode (r_opcode),
    .a      (r_a),
    .b      (r_b),
    .result (w_alu_result),
    .bad_op (w_alu_bad_op)
  );

  assign w_in_frame = (r_state == S_GET_OP) || (r_state == S_GET_A) || (r_state == S_GET_B);
  assign w_is_send  = (r_state == S_SEND_ST) || (r_state == S_SEND_HI) || (r_state == S_SEND_LO);
  assign w_in_resp  = (r_state == S_EXEC) || w_is_send;

  // The transmitter lowers tx_ready one cycle late, so the ready seen while our
  // pulse is on the wire is stale and must be ignored.
  assign w_send_go  = tx_ready && !r_tx_valid;

  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    w_send_byte  = 8'h00;
    case (r_state)
      S_IDLE:    if (rx_valid && (rx_data == SYNC_BYTE)) w_next_state = S_GET_OP;
      S_GET_OP, S_GET_A, S_GET_B: begin
        // A byte arriving on the timeout cycle wins over the timeout.
        if (rx_valid) begin
          case (r_state)
            S_GET_OP: w_next_state = S_GET_A;
            S_GET_A:  w_next_state = S_GET_B;
            default:  w_next_state = S_EXEC;
          endcase
        end else if (r_to_cnt == TO_LAST) begin
          w_next_state = S_IDLE;
          w_timeout    = 1'b1;
        end
      end
      S_EXEC:    w_next_state = S_SEND_ST;
      S_SEND_ST: begin
        w_send_byte = r_status;
        if (w_send_go) w_next_state = S_SEND_HI;
      end
      S_SEND_HI: begin
        w_send_byte = r_result[15:8];
        if (w_send_go) w_next_state = S_SEND_LO;
      end
      S_SEND_LO: begin
        w_send_byte = r_result[7:0];
        if (w_send_go) w_next_state = S_IDLE;
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opcode    <= 8'h00;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_result    <= 16'h0000;
      r_status    <= 8'h00;
      r_to_cnt    <= '0;
      r_frame_err <= '0;
      r_overrun   <= '0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);

      if (w_in_frame && !rx_valid && !w_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                                       r_to_cnt <= '0;

      if (rx_valid) begin
        if (r_state == S_GET_OP) r_opcode <= rx_data;
        if (r_state == S_GET_A)  r_a      <= rx_data;
        if (r_state == S_GET_B)  r_b      <= rx_data;
      end

      if (r_state == S_EXEC) begin
        r_result <= w_alu_result;
        r_status <= w_alu_bad_op ? ST_BAD_OP : ST_OK;
      end

      r_tx_valid <= 1'b0;
      if (w_is_send && w_send_go) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_send_byte;
      end

      if (w_timeout && (r_frame_err != '1)) r_frame_err <= r_frame_err + ERR_CNT_W'(1);
      if (w_in_resp && rx_valid && (r_overrun != '1)) r_overrun <= r_overrun + ERR_CNT_W'(1);
    end
  end

  assign tx_data       = r_tx_data;
  assign tx_valid      = r_tx_valid;
  assign busy          = r_busy;
  assign frame_err_cnt = r_frame_err;
  assign overrun_cnt   = r_overrun;

endmodule

// File: tb/tb_uart_cal_ctrl.sv
// tb/tb_uart_cal_ctrl.sv - self-checking bench for uart_cal_ctrl
module tb_uart_cal_ctrl;

  localparam int TO_CYC = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic [7:0] frame_err_cnt;
  logic [7:0] overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_pulse = -10;
  int pulse_cnt  = 0;
  int pc0;
  logic [7:0] exp_q[$];

  uart_cal_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO_CYC), .ERR_CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .frame_err_cnt (frame_err_cnt),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    case (op)
      8'h00: r = 16'(a) + 16'(b);
      8'h01: r = 16'(a) - 16'(b);
      8'h02: r = 16'(a) * 16'(b);
      8'h03: r = {8'h00, a & b};
      8'h04: r = {8'h00, a | b};
      8'h05: r = {8'h00, a ^ b};
      default: return 24'hE10000;
    endcase
    return {8'h00, r};
  endfunction

  // Scoreboard side: every tx pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      pulse_cnt++;
      check("tx_spacing_ge2", 32'((cyc - last_pulse) >= 2), 32'd1);
      last_pulse = cyc;
      check("tx_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // Called at a falling edge; leaves at the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [23:0] e;
    e = model(op, a, b);
    exp_q.push_back(e[23:16]);
    exp_q.push_back(e[15:8]);
    exp_q.push_back(e[7:0]);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err_cnt), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send_frame(8'h00, 8'h12, 8'h34);
    check("busy_during_frame", 32'(busy), 32'd1);
    wait_idle("add");

    send_frame(8'h02, 8'hFF, 8'hFF);
    wait_idle("mul");
    send_frame(8'h01, 8'h01, 8'h02);
    wait_idle("sub");

    send_frame(8'h07, 8'h01, 8'h01);
    wait_idle("bad_op");
    send_byte(8'h11);
    send_byte(8'h22);
    check("noise_ignored_busy", 32'(busy), 32'd0);
    send_frame(8'h05, 8'hF0, 8'h3C);
    wait_idle("xor");

    // Timeout after SYNC, OPCODE.
    pc0 = pulse_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    repeat (TO_CYC + 5) @(negedge clk);
    check("to_frame_err", 32'(frame_err_cnt), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_no_tx", 32'(pulse_cnt), 32'(pc0));

    // Byte sampled on the very cycle the counter reaches TIMEOUT_CYC-1.
    begin
      logic [23:0] e;
      e = model(8'h01, 8'h09, 8'h03);
      exp_q.push_back(e[23:16]);
      exp_q.push_back(e[15:8]);
      exp_q.push_back(e[7:0]);
      send_byte(8'hA5);
      repeat (TO_CYC - 1) @(negedge clk);
      send_byte(8'h01);
      send_byte(8'h09);
      send_byte(8'h03);
    end
    wait_idle("to_edge");
    check("to_edge_frame_err", 32'(frame_err_cnt), 32'd1);

    // Overrun while the transmitter is stalled.
    pc0 = pulse_cnt;
    tx_ready = 1'b0;
    send_frame(8'h00, 8'h7F, 8'h01);
    repeat (10) @(negedge clk);
    send_byte(8'h33);
    repeat (10) @(negedge clk);
    send_byte(8'hA5);
    repeat (28) @(negedge clk);
    check("stall_no_tx", 32'(pulse_cnt), 32'(pc0));
    check("overrun_cnt", 32'(overrun_cnt), 32'd2);
    check("stall_busy", 32'(busy), 32'd1);
    tx_ready = 1'b1;
    wait_idle("overrun");

    // Reset while the STATUS pulse is on the wire (state is SEND_HI).
    send_frame(8'h02, 8'h10, 8'h10);
    begin
      int n = 0;
      while (!tx_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("status_pulse_seen", 32'(tx_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_tx_valid", 32'(tx_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_frame_err", 32'(frame_err_cnt), 32'd0);
    check("arst_overrun", 32'(overrun_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pc0 = pulse_cnt;
    repeat (10) @(negedge clk);
    check("post_rst_no_tx", 32'(pulse_cnt), 32'(pc0));

    send_frame(8'h03, 8'hAC, 8'h0F);
    wait_idle("and");
    send_frame(8'h04, 8'hA0, 8'h05);
    wait_idle("or");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
